add_pipe: RTL and testbench

//  Parametrised, elastic, pipelined unsigned adder: C = A + B with carry/overflow flag.

---
 rtl/add_pipe_pkg.sv | 15 +
 rtl/add_pipe_slice.sv | 32 +++
 rtl/add_pipe.sv | 77 +++++++
 tb/tb_add_pipe.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/add_pipe_pkg.sv
// rtl/add_pipe_pkg.sv - shared constants and payload widths for the elastic pipelined adder
package add_pipe_pkg;

  localparam int ADD_WRAP   = 0;
  localparam int ADD_SAT    = 1;
  localparam int STAGES_MAX = 4;

  // Slice payload is {carry, c}: one carry bit above the WIDTH-bit sum.
  localparam int CARRY_W = 1;

  function automatic int payload_w(input int width);
    return width + CARRY_W;
  endfunction

endpackage

// File: rtl/add_pipe_slice.sv
// rtl/add_pipe_slice.sv - one elastic register slice: holds {carry, c} with valid/ready on both sides
module add_pipe_slice
  import add_pipe_pkg::*;
#(
  parameter int PW = payload_w(16)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_vld,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
);

  // Loading with in_vld=0 drains the slice; data is only replaced by real input.
  assign in_ready = !out_vld || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_data <= '0;
    end else if (in_ready) begin
      out_vld <= in_vld;
      if (in_vld) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/add_pipe.sv
// rtl/add_pipe.sv - elastic pipelined unsigned adder with wrap/saturate mode and overflow counter
module add_pipe
  import add_pipe_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2,
  parameter int SAT    = ADD_WRAP,
  parameter int CNTW   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             carry,
  output logic [CNTW-1:0]  ovf_cnt,
  input  logic             ovf_clr
);

  localparam int PW = payload_w(WIDTH);

  if (STAGES < 1 || STAGES > STAGES_MAX || WIDTH < 2) begin : g_bad_param
    $error("add_pipe: WIDTH must be >= 2 and STAGES within 1..%0d", STAGES_MAX);
  end

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] c0;

  assign sum = {1'b0, a} + {1'b0, b};
  assign c0  = (SAT == ADD_SAT && sum[WIDTH]) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];

  logic          vld [STAGES+1];
  logic [PW-1:0] pl  [STAGES+1];

  assign vld[0] = in_valid;
  assign pl[0]  = {sum[WIDTH], c0};

  // Each slice keeps its own ready nets so the ripple stays acyclic per signal.
  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    logic up_rdy;
    logic dn_rdy;

    if (k == STAGES - 1) begin : g_tail
      assign dn_rdy = out_ready;
    end else begin : g_link
      assign dn_rdy = g_slice[k+1].up_rdy;
    end

    add_pipe_slice #(.PW(PW)) u_slice (
      .clk       (clk),
      .rst       (rst),
      .in_vld    (vld[k]),
      .in_ready  (up_rdy),
      .in_data   (pl[k]),
      .out_vld   (vld[k+1]),
      .out_ready (dn_rdy),
      .out_data  (pl[k+1])
    );
  end

  assign in_ready   = g_slice[0].up_rdy;
  assign out_valid  = vld[STAGES];
  assign {carry, c} = pl[STAGES];

  always_ff @(posedge clk) begin
    if (rst || ovf_clr) begin
      ovf_cnt <= '0;
    end else if (out_valid && out_ready && carry && (ovf_cnt != {CNTW{1'b1}})) begin
      ovf_cnt <= ovf_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_add_pipe.sv
// tb/tb_add_pipe.sv - directed scoreboard bench for add_pipe, wrap and saturate instances side by side
module tb_add_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_ready;
  logic        ovf_clr;

  logic        in_ready_w, out_valid_w, carry_w;
  logic [15:0] c_w;
  logic [3:0]  ovf_cnt_w;
  logic        in_ready_s, out_valid_s, carry_s;
  logic [15:0] c_s;
  logic [7:0]  ovf_cnt_s;

  add_pipe #(.WIDTH(16), .STAGES(2), .SAT(0), .CNTW(4)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .a(a), .b(b), .out_valid(out_valid_w), .out_ready(out_ready),
    .c(c_w), .carry(carry_w), .ovf_cnt(ovf_cnt_w), .ovf_clr(ovf_clr)
  );

  add_pipe #(.WIDTH(16), .STAGES(2), .SAT(1), .CNTW(8)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .a(a), .b(b), .out_valid(out_valid_s), .out_ready(out_ready),
    .c(c_s), .carry(carry_s), .ovf_cnt(ovf_cnt_s), .ovf_clr(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] cw;
    logic [15:0] cs;
    logic        cy;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   lats[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   n_out = 0;
  int   ovf_w = 0;
  int   ovf_s = 0;
  logic acc_flag = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes at negedge, update scoreboard/model, return #1 after posedge.
  task automatic cycle();
    logic [16:0] s;
    exp_t        e;
    logic        hs;
    @(negedge clk);
    acc_flag = 1'b0;
    if (rst) begin
      sb.delete();
      ovf_w = 0;
      ovf_s = 0;
    end else begin
      hs = out_valid_w && out_ready;
      e.cy = 1'b0;
      if (hs) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("c_wrap", c_w, e.cw);
          chk("carry_wrap", carry_w, e.cy);
          chk("valid_sat", out_valid_s, 1);
          chk("c_sat", c_s, e.cs);
          chk("carry_sat", carry_s, e.cy);
          lats.push_back(cyc - e.acc);
          n_out++;
        end
      end
      if (ovf_clr) begin
        ovf_w = 0;
        ovf_s = 0;
      end else if (hs && e.cy) begin
        if (ovf_w < 15) ovf_w++;
        if (ovf_s < 255) ovf_s++;
      end
      if (in_valid && in_ready_w) begin
        s = {1'b0, a} + {1'b0, b};
        e.cw = s[15:0];
        e.cs = s[16] ? 16'hFFFF : s[15:0];
        e.cy = s[16];
        e.acc = cyc;
        sb.push_back(e);
        acc_flag = 1'b1;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send(input logic [15:0] av, input logic [15:0] bv);
    a = av;
    b = bv;
    in_valid = 1'b1;
    for (int t = 0; t < 20; t++) begin
      cycle();
      if (acc_flag) break;
    end
    chk("send_accepted", acc_flag, 1);
  endtask

  task automatic drain(input int max);
    in_valid = 1'b0;
    for (int t = 0; t < max && sb.size() != 0; t++) cycle();
    chk("drain_empty", sb.size(), 0);
  endtask

  int base;

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1; ovf_clr = 1'b0;
    #1;
    cycle();
    cycle();
    rst = 1'b0;
    chk("rst_out_valid", out_valid_w, 0);
    chk("rst_c", c_w, 0);
    chk("rst_carry", carry_w, 0);
    chk("rst_ovf", ovf_cnt_w, 0);
    chk("rst_in_ready", in_ready_w, 1);
    chk("rst_out_valid_sat", out_valid_s, 0);

    // back-to-back with latency check
    lats.delete();
    send(16'd1, 16'd1);
    send(16'd10, 16'd20);
    drain(10);
    chk("lat_count", lats.size(), 2);
    if (lats.size() == 2) begin
      chk("lat_first", lats[0], 2);
      chk("lat_second", lats[1], 2);
    end

    // carry, wrap vs saturate, edge values
    send(16'hFFFF, 16'h0001);
    drain(10);
    chk("ovf_one_wrap", ovf_cnt_w, 1);
    chk("ovf_one_sat", ovf_cnt_s, 1);
    send(16'hFFFF, 16'hFFFF);
    send(16'h0000, 16'h0000);
    send(16'h8000, 16'h7FFF);
    drain(10);
    chk("ovf_two_wrap", ovf_cnt_w, 2);

    // backpressure
    base = n_out;
    out_ready = 1'b0;
    send(16'd100, 16'd300);
    send(16'd101, 16'd300);
    in_valid = 1'b0;
    #1;
    chk("full_in_ready", in_ready_w, 0);
    a = 16'd102; b = 16'd300; in_valid = 1'b1;
    for (int t = 0; t < 3; t++) begin
      cycle();
      chk("stall_no_accept", acc_flag, 0);
      chk("stall_valid", out_valid_w, 1);
      chk("stall_hold_c", c_w, 16'd400);
    end
    out_ready = 1'b1;
    send(16'd102, 16'd300);
    send(16'd103, 16'd300);
    send(16'd104, 16'd300);
    drain(10);
    chk("bp_count", n_out - base, 5);

    // overflow counter saturation and clear
    for (int i = 0; i < 20; i++) send(16'hFFFF, 16'h0001);
    drain(10);
    chk("ovf_sat_wrap", ovf_cnt_w, 15);
    chk("ovf_model_wrap", ovf_cnt_w, ovf_w);
    chk("ovf_model_sat", ovf_cnt_s, ovf_s);
    send(16'hFFFF, 16'h0001);
    in_valid = 1'b0;
    for (int t = 0; t < 10; t++) begin
      if (out_valid_w) begin
        ovf_clr = 1'b1;
        cycle();
        ovf_clr = 1'b0;
        break;
      end
      cycle();
    end
    chk("ovf_clr_wrap", ovf_cnt_w, 0);
    chk("ovf_clr_sat", ovf_cnt_s, 0);
    chk("clr_drained", sb.size(), 0);

    // reset with full chain
    send(16'hFFFF, 16'h0001);
    drain(10);
    out_ready = 1'b0;
    send(16'd7, 16'd8);
    send(16'd9, 16'd9);
    in_valid = 1'b0;
    #1;
    chk("pre_rst_full", in_ready_w, 0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("post_rst_valid", out_valid_w, 0);
    chk("post_rst_in_ready", in_ready_w, 1);
    chk("post_rst_ovf", ovf_cnt_w, 0);
    out_ready = 1'b1;
    lats.delete();
    send(16'd3, 16'd4);
    drain(10);
    chk("post_rst_lat_count", lats.size(), 1);
    if (lats.size() == 1) chk("post_rst_lat", lats[0], 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
